// File: rtl/recip_norm_pkg.sv
// Shared definitions for the reciprocal normalizer: FSM state encoding and default width.
package recip_norm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int N_DEFAULT = 16;

endpackage

// File: rtl/recip_norm_lod.sv
// Leading-one detector: one-hot flag on the most significant set bit of d (all zero for d = 0).
module lod #(
  parameter int N = 16
) (
  input  logic [N-1:0] d,
  output logic [N-1:0] onehot
);

  // Scan upward so the highest set bit is the last one to claim the output
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (d[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/recip_norm.sv
// Normalized reciprocal: s = leading-zero count of d, q = floor(2^(2N-1) / (d << s)),
// computed by a one-bit-per-cycle restoring divider with a valid/ready handshake on each side.
module recip_norm
  import recip_norm_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_d,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_q,
  output logic [$clog2(N)-1:0] out_shift,
  output logic                 out_dz
);

  localparam int SW = $clog2(N);

  state_t        state, state_nx;
  logic [N-1:0]  d_r, dn, q_r, onehot;
  logic [N:0]    rem, rem2, rem_nx;
  logic          ge;
  logic [SW-1:0] cnt, s_r, idx, s_enc;
  logic          dz_r;

  // The only case where the quotient would need N+1 bits is dn = 2^(N-1); clamp it to all ones
  function automatic logic [N-1:0] sat_q(input logic [N-1:0] q, input logic [N-1:0] dnorm);
    logic [N-1:0] half;
    half        = '0;
    half[N-1]   = 1'b1;
    return (dnorm == half) ? '1 : q;
  endfunction

  lod #(.N(N)) u_lod (
    .d      (d_r),
    .onehot (onehot)
  );

  // One-hot to bit index, then convert to a left-shift amount
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) idx = idx | SW'(i);
    end
    s_enc = SW'(N - 1) - idx;
  end

  // Restoring division step; rem < dn < 2^N so doubling never loses the top bit
  always_comb begin
    rem2   = {rem[N-1:0], 1'b0};
    ge     = (rem2 >= {1'b0, dn});
    rem_nx = ge ? (rem2 - {1'b0, dn}) : rem2;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = NORM;
      NORM: state_nx = (d_r == '0) ? DONE : DIV;
      DIV:  if (cnt == '0) state_nx = DONE;
      DONE: if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);

  // Control, remainder and output registers; cleared by the asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      s_r       <= '0;
      dz_r      <= 1'b0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_shift <= '0;
      out_dz    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        NORM: begin
          s_r      <= s_enc;
          dz_r     <= (d_r == '0);
          rem      <= '0;
          rem[N-1] <= 1'b1;
          cnt      <= SW'(N - 1);
        end
        DIV: begin
          rem <= rem_nx;
          cnt <= cnt - 1'b1;
        end
        DONE: begin
          // First DONE cycle publishes the result; it then holds until accepted
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_q     <= dz_r ? '1 : sat_q(q_r, dn);
            out_shift <= dz_r ? '0 : s_r;
            out_dz    <= dz_r;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand, normalized divisor and quotient datapath registers
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (in_valid) d_r <= in_d;
      NORM: begin
        dn  <= d_r << s_enc;
        q_r <= '0;
      end
      DIV:  q_r <= {q_r[N-2:0], ge};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_recip_norm.sv
// Directed bench for recip_norm: hand-computed reciprocals, latency, stall and reset behaviour.
module tb_recip_norm;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_d;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_q;
  logic [3:0]  out_shift;
  logic        out_dz;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  recip_norm #(.N(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_d      (in_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_shift (out_shift),
    .out_dz    (out_dz)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Accept one operand, measure latency, check result, optionally stall, then drain
  task automatic run_op(input logic [15:0] d, input logic [15:0] eq, input logic [3:0] es,
                        input logic edz, input int elat, input int hold);
    int lat;
    @(negedge clk);
    in_d     = d;
    in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_d     = 16'h0;
    lat      = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("latency_d%04h", d), lat, elat);
    check($sformatf("q_d%04h", d), out_q, eq);
    check($sformatf("shift_d%04h", d), out_shift, es);
    check($sformatf("dz_d%04h", d), out_dz, edz);
    check($sformatf("in_ready_busy_d%04h", d), in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_q", out_q, eq);
      check("hold_shift", out_shift, es);
      check("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("drain_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 1);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_d      = 16'h0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_q", out_q, 0);
    check("rst_out_shift", out_shift, 0);
    check("rst_out_dz", out_dz, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(16'h0003, 16'hAAAA, 4'd14, 1'b0, 18, 0);
    run_op(16'h0005, 16'hCCCC, 4'd13, 1'b0, 18, 0);
    run_op(16'hFFFF, 16'h8000, 4'd0,  1'b0, 18, 0);
    run_op(16'h0001, 16'hFFFF, 4'd15, 1'b0, 18, 0);
    run_op(16'h8000, 16'hFFFF, 4'd0,  1'b0, 18, 0);
    run_op(16'h00FF, 16'h8080, 4'd8,  1'b0, 18, 0);
    run_op(16'h0000, 16'hFFFF, 4'd0,  1'b1, 2,  0);
    run_op(16'h0003, 16'hAAAA, 4'd14, 1'b0, 18, 10);

    // Reset mid-division: operation must vanish
    @(negedge clk);
    in_d     = 16'h0003;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_q", out_q, 0);
    check("midrst_out_shift", out_shift, 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check("midrst_no_valid", seen, 0);
    run_op(16'h0005, 16'hCCCC, 4'd13, 1'b0, 18, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
